// File: rtl/alu_cmd_sequencer.sv
// Accumulator front end for the combinational 4-bit ALU core: queues {load, op, operand}
// commands, drives the core, waits for its ripple paths to settle and returns a flagged result.
module alu_cmd_sequencer #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_operand,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_zero,
    output logic       res_divz,
    output logic [3:0] acc,
    output logic       busy,
    output logic [3:0] fifo_count
);

    localparam int              PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [3:0]       DEPTH_C    = 4'(DEPTH);
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [8:0]       fifo_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [3:0]       count_r;
    logic [7:0]       settle_cnt_r;
    logic [3:0]       acc_r;
    logic [3:0]       alu_a_r;
    logic [3:0]       alu_b_r;
    logic [3:0]       alu_op_r;
    logic [7:0]       res_data_r;
    logic             res_carry_r;
    logic             res_divz_r;

    logic       ready_s;
    logic       push_s;
    logic       pop_s;
    logic [8:0] head_s;
    logic       head_load_s;
    logic [3:0] head_op_s;
    logic [3:0] head_opnd_s;
    logic       head_divz_s;
    logic       carry_s;
    logic       acc_upd_s;

    // Handshake and FIFO head decode
    always_comb begin
        ready_s     = (count_r < DEPTH_C) && !rst;
        push_s      = cmd_valid && ready_s;
        pop_s       = (state_r == IDLE) && (count_r != 4'd0);
        head_s      = fifo_mem_r[rd_ptr_r];
        head_load_s = head_s[8];
        head_op_s   = head_s[7:4];
        head_opnd_s = head_s[3:0];
        head_divz_s = !head_s[8] && (head_s[7:4] == 4'd3) && (head_s[3:0] == 4'd0);
    end

    // Carry meaning and accumulator write-back depend on the executing op
    always_comb begin
        carry_s   = 1'b0;
        acc_upd_s = 1'b1;
        case (alu_op_r)
            4'd0, 4'd1, 4'd10, 4'd11, 4'd15: carry_s = alu_result[4];
            4'd2:                            carry_s = |alu_result[7:4];
            default:                         carry_s = 1'b0;
        endcase
        case (alu_op_r)
            4'd12, 4'd13, 4'd14: acc_upd_s = 1'b0;
            default:             acc_upd_s = 1'b1;
        endcase
    end

    // Command storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_load, cmd_op, cmd_operand};
        end
    end

    // FIFO pointers and occupancy; a same-edge push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    if (head_load_s || head_divz_s) state_nxt_s = RESP;
                    else                            state_nxt_s = SETTLE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_r == 8'd0) state_nxt_s = RESP;
                else                      state_nxt_s = SETTLE;
            end
            RESP: begin
                if (res_ready) state_nxt_s = IDLE;
                else           state_nxt_s = RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: loads and divide-by-zero bypass the core; other ops sample it after settling
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= 4'd0;
            alu_a_r      <= 4'd0;
            alu_b_r      <= 4'd0;
            alu_op_r     <= 4'd0;
            settle_cnt_r <= 8'd0;
            res_data_r   <= 8'd0;
            res_carry_r  <= 1'b0;
            res_divz_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        if (head_load_s) begin
                            acc_r       <= head_opnd_s;
                            res_data_r  <= {4'd0, head_opnd_s};
                            res_carry_r <= 1'b0;
                            res_divz_r  <= 1'b0;
                        end else if (head_divz_s) begin
                            res_data_r  <= 8'd0;
                            res_carry_r <= 1'b0;
                            res_divz_r  <= 1'b1;
                        end else begin
                            alu_a_r      <= acc_r;
                            alu_b_r      <= head_opnd_s;
                            alu_op_r     <= head_op_s;
                            settle_cnt_r <= SETTLE_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r == 8'd0) begin
                        res_data_r  <= alu_result;
                        res_carry_r <= carry_s;
                        res_divz_r  <= 1'b0;
                        if (acc_upd_s) acc_r <= alu_result[3:0];
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 8'd1;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign cmd_ready  = ready_s;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_op     = alu_op_r;
    assign res_valid  = (state_r == RESP);
    assign res_data   = res_data_r;
    assign res_carry  = res_carry_r;
    assign res_zero   = (res_data_r == 8'd0);
    assign res_divz   = res_divz_r;
    assign acc        = acc_r;
    assign busy       = (state_r != IDLE) || (count_r != 4'd0);
    assign fifo_count = count_r;

endmodule
